booth_seq_ctrl: RTL and testbench

- Sequential radix-2 Booth multiplier controller for 8-bit signed operands, yielding a 16-bit signed product.
- Owns the accumulator, multiplier shift register, iteration counter and FSM.
- Drives one shared adder_8bit instance once per iteration, selecting add, subtract or no-op.
- Sits between an operand source (start/busy/done handshake) and downstream logic that consumes the product.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/adder_8bit.sv | 13 +
 rtl/booth_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_booth_seq_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types, width constant and Booth recoding helper for the sequential
// radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Map the {Q[0], q_1} bit pair onto the operation for this iteration.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple adder with carry-in. It is shared by the Booth controller,
// which uses it once per iteration.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum
);

  // Modulo-256 sum. The caller recovers the true sign from the overflow.
  assign sum = a + b + {7'd0, cin};

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller. It performs one add, subtract
// or no-op step per cycle on a shared adder and needs WIDTH cycles per product.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH != BOOTH_WIDTH) begin : g_width_check
    $error("booth_seq_ctrl: WIDTH must equal the adder_8bit width");
  end

  state_t               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     q_r;
  logic                 q1_r;
  logic [WIDTH-1:0]     m_r;
  logic [CNT_W-1:0]     count_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  booth_op_t            op_s;
  logic [WIDTH-1:0]     b_s;
  logic                 cin_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 ovf_s;
  logic                 sign_s;
  logic [WIDTH-1:0]     a_next_s;
  logic [WIDTH-1:0]     q_next_s;

  // Select the adder operand and carry-in from the recoded bit pair.
  always_comb begin
    op_s  = booth_decode({q_r[0], q1_r});
    b_s   = {WIDTH{1'b0}};
    cin_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        b_s   = m_r;
        cin_s = 1'b0;
      end
      OP_SUB: begin
        b_s   = ~m_r;
        cin_s = 1'b1;
      end
      default: begin
        b_s   = {WIDTH{1'b0}};
        cin_s = 1'b0;
      end
    endcase
  end

  adder_8bit u_adder (
    .a   (a_r),
    .b   (b_s),
    .cin (cin_s),
    .sum (sum_s)
  );

  // Shift the 9-bit true sum right. The corrected sign keeps M = -128 exact.
  always_comb begin
    ovf_s    = (a_r[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
    sign_s   = sum_s[WIDTH-1] ^ ovf_s;
    a_next_s = {sign_s, sum_s[WIDTH-1:1]};
    q_next_s = {sum_s[0], q_r[WIDTH-1:1]};
  end

  // Sequencing FSM that owns the datapath registers and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      q1_r      <= 1'b0;
      m_r       <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {2*WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= {WIDTH{1'b0}};
            q_r     <= multiplier;
            q1_r    <= 1'b0;
            m_r     <= multiplicand;
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_next_s;
          q_r     <= q_next_s;
          q1_r    <= q_r[0];
          count_r <= count_r + CNT_W'(1);
          if (count_r == CNT_W'(WIDTH - 1)) begin
            product_r <= {a_next_s, q_next_s};
            done_r    <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl. A cycle-level transaction model gives
// the expected busy, done and product values, and each product is M*Q in plain
// signed arithmetic.
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          phase    = 0;
  logic [15:0] last_prod = 16'h0000;
  logic [15:0] pend      = 16'h0000;

  booth_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int mi;
    int qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    return 16'(mi * qi);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge. phase counts the cycles
  // since acceptance: 0 means idle, 1..8 is the run, and 9 is the done cycle.
  task automatic step(input logic st, input logic [7:0] m, input logic [7:0] q);
    chk("busy", {15'd0, busy}, {15'd0, (phase != 0)});
    chk("done", {15'd0, done}, {15'd0, (phase == 9)});
    if (phase == 9) last_prod = pend;
    chk("product", product, last_prod);
    start  = st;
    mcand  = m;
    mplier = q;
    @(posedge clk);
    if (phase == 0 && st) begin
      phase = 1;
      pend  = ref_mul(m, q);
    end else if (phase == 9) begin
      phase = 0;
    end else if (phase != 0) begin
      phase++;
    end
    @(negedge clk);
  endtask

  // Run one full operation. Operands are scrambled while the operation is busy.
  task automatic op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] want,
                    input bit noisy, input string tag);
    step(1'b1, m, q);
    for (int i = 0; i < 9; i++)
      step(noisy ? 1'($urandom) : 1'b0, 8'($urandom), 8'($urandom));
    start = 1'b0;
    chk(tag, product, want);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = 8'h00;
    mplier = 8'h00;
    #2;
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_done", {15'd0, done}, 16'h0000);
    chk("rst_product", product, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(8'd3,   8'd5,   16'h000F, 1'b0, "3x5");
    op(8'hF9,  8'd6,   16'hFFD6, 1'b1, "m7x6");
    op(8'd0,   8'hFF,  16'h0000, 1'b1, "0xm1");
    op(8'h80,  8'h80,  16'h4000, 1'b1, "m128xm128");
    op(8'h7F,  8'h80,  16'hC080, 1'b0, "127xm128");
    op(8'h80,  8'h7F,  16'hC080, 1'b1, "m128x127");

    // Hold start continuously while the operands change every cycle.
    for (int i = 0; i < 45; i++) step(1'b1, 8'($urandom), 8'($urandom));
    while (phase != 0) step(1'b0, 8'($urandom), 8'($urandom));

    // Apply an asynchronous reset partway through the run.
    step(1'b1, 8'd9, 8'd11);
    for (int i = 0; i < 4; i++) step(1'b0, 8'($urandom), 8'($urandom));
    rst = 1'b1;
    #1;
    chk("midrst_busy", {15'd0, busy}, 16'h0000);
    chk("midrst_done", {15'd0, done}, 16'h0000);
    chk("midrst_product", product, 16'h0000);
    phase     = 0;
    last_prod = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 8'($urandom), 8'($urandom));
    op(8'd2, 8'hFD, 16'hFFFA, 1'b0, "2xm3");

    for (int i = 0; i < 800; i++) begin
      logic [7:0] m;
      logic [7:0] q;
      m = 8'($urandom);
      q = 8'($urandom);
      op(m, q, ref_mul(m, q), 1'(i), "random");
    end
    step(1'b0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
